// File: rtl/rocc_cmd_arbiter_if.sv
// Core-side and accelerator-side RoCC command/response bundle for rocc_cmd_arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface rocc_cmd_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 64
);
    logic [N_REQ-1:0]           req_cmd_valid;
    logic [N_REQ-1:0]           req_cmd_ready;
    logic [N_REQ-1:0][6:0]      req_cmd_funct;
    logic [N_REQ-1:0][4:0]      req_cmd_rd;
    logic [N_REQ-1:0]           req_cmd_xd;
    logic [N_REQ-1:0][XLEN-1:0] req_cmd_rs1;
    logic [N_REQ-1:0][XLEN-1:0] req_cmd_rs2;
    logic [N_REQ-1:0]           req_resp_valid;
    logic [N_REQ-1:0]           req_resp_ready;
    logic [4:0]                 req_resp_rd;
    logic [XLEN-1:0]            req_resp_data;
    logic [N_REQ-1:0]           req_busy;

    logic                       acc_cmd_valid;
    logic                       acc_cmd_ready;
    logic [6:0]                 acc_cmd_funct;
    logic [4:0]                 acc_cmd_rd;
    logic                       acc_cmd_xd;
    logic [XLEN-1:0]            acc_cmd_rs1;
    logic [XLEN-1:0]            acc_cmd_rs2;
    logic                       acc_resp_valid;
    logic                       acc_resp_ready;
    logic [4:0]                 acc_resp_rd;
    logic [XLEN-1:0]            acc_resp_data;
    logic                       acc_busy;
    logic                       resp_orphan;

    modport slave (
        input  req_cmd_valid, req_cmd_funct, req_cmd_rd, req_cmd_xd, req_cmd_rs1, req_cmd_rs2,
        input  req_resp_ready,
        output req_cmd_ready, req_resp_valid, req_resp_rd, req_resp_data, req_busy,
        output acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
        input  acc_cmd_ready,
        input  acc_resp_valid, acc_resp_rd, acc_resp_data, acc_busy,
        output acc_resp_ready, resp_orphan
    );

    modport master (
        output req_cmd_valid, req_cmd_funct, req_cmd_rd, req_cmd_xd, req_cmd_rs1, req_cmd_rs2,
        output req_resp_ready,
        input  req_cmd_ready, req_resp_valid, req_resp_rd, req_resp_data, req_busy,
        input  acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
        output acc_cmd_ready,
        output acc_resp_valid, acc_resp_rd, acc_resp_data, acc_busy,
        input  acc_resp_ready, resp_orphan
    );
endinterface

// File: rtl/rocc_cmd_arbiter.sv
// Round-robin sharing of one RoCC accelerator between N_REQ sources; an in-order
// ID FIFO remembers who issued each xd=1 command so responses route back.

// Per-requester outstanding-response counter and busy indication.
module rocc_cmd_arbiter_lane #(
    parameter int CNT_W = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic cmd_wait,
    input  logic acc_busy,
    output logic busy
);
    logic [CNT_W-1:0] out_cnt;

    always_ff @(posedge clock) begin
        if (reset)            out_cnt <= '0;
        else if (inc && !dec) out_cnt <= out_cnt + 1'b1;
        else if (dec && !inc) out_cnt <= out_cnt - 1'b1;
    end

    assign busy = (out_cnt != '0) | acc_busy | cmd_wait;
endmodule

module rocc_cmd_arbiter #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input logic            clock,
    input logic            reset,
    rocc_cmd_arbiter_if.slave bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [ID_W-1:0]            rr_ptr, grant, head;
    logic [DEPTH-1:0][ID_W-1:0] id_fifo;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [N_REQ-1:0]           eligible, inc, dec, cmd_wait, busy;
    logic                       full, any_elig, cmd_fire, push, pop, has_id, orphan;

    // (base + k) mod N_REQ without a divider; base and k are both < N_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        logic [ID_W:0] s;
        s = {1'b0, base} + (ID_W+1)'(k);
        if (s >= (ID_W+1)'(N_REQ)) s = s - (ID_W+1)'(N_REQ);
        return s[ID_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Full is judged on the registered count only; a same-cycle pop does not free a slot.
    assign full = (count == DEPTH_C);
    assign eligible = bus.req_cmd_valid & ~(bus.req_cmd_xd & {N_REQ{full}});
    assign any_elig = |eligible;

    always_comb begin
        grant = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (eligible[wrap_idx(rr_ptr, k)]) grant = wrap_idx(rr_ptr, k);
    end

    always_comb begin
        bus.acc_cmd_valid = any_elig;
        bus.acc_cmd_funct = '0;
        bus.acc_cmd_rd    = '0;
        bus.acc_cmd_xd    = 1'b0;
        bus.acc_cmd_rs1   = '0;
        bus.acc_cmd_rs2   = '0;
        if (any_elig) begin
            bus.acc_cmd_funct = bus.req_cmd_funct[grant];
            bus.acc_cmd_rd    = bus.req_cmd_rd[grant];
            bus.acc_cmd_xd    = bus.req_cmd_xd[grant];
            bus.acc_cmd_rs1   = bus.req_cmd_rs1[grant];
            bus.acc_cmd_rs2   = bus.req_cmd_rs2[grant];
        end
    end

    assign cmd_fire = any_elig & bus.acc_cmd_ready;
    assign push     = cmd_fire & bus.acc_cmd_xd;

    assign has_id = (count != '0);
    assign head   = id_fifo[rd_ptr];
    // With no ID to route to, the response is swallowed and flagged as orphan.
    assign bus.acc_resp_ready = has_id ? bus.req_resp_ready[head] : 1'b1;
    assign pop                = has_id & bus.acc_resp_valid & bus.acc_resp_ready;
    assign bus.req_resp_rd    = bus.acc_resp_rd;
    assign bus.req_resp_data  = bus.acc_resp_data;
    assign bus.resp_orphan    = orphan;
    assign bus.req_busy       = busy;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign bus.req_cmd_ready[i]  = (grant == ID_W'(i)) & cmd_fire;
        assign bus.req_resp_valid[i] = has_id & (head == ID_W'(i)) & bus.acc_resp_valid;
        assign inc[i]      = push & (grant == ID_W'(i));
        assign dec[i]      = pop & (head == ID_W'(i));
        assign cmd_wait[i] = bus.req_cmd_valid[i] & ~bus.req_cmd_ready[i];

        rocc_cmd_arbiter_lane #(.CNT_W(CNT_W)) u_lane (
            .clock    (clock),
            .reset    (reset),
            .inc      (inc[i]),
            .dec      (dec[i]),
            .cmd_wait (cmd_wait[i]),
            .acc_busy (bus.acc_busy),
            .busy     (busy[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            orphan <= 1'b0;
        end else begin
            if (cmd_fire) rr_ptr <= wrap_idx(grant, 1);
            if (push) begin
                id_fifo[wr_ptr] <= grant;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!has_id && bus.acc_resp_valid) orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Directed bench for rocc_cmd_arbiter: expected commands/responses are queued by the
// stimulus and checked by a negedge monitor whenever the DUT hands one over.
module tb_rocc_cmd_arbiter;
    localparam int N = 2, XL = 64, D = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rocc_cmd_arbiter_if #(.N_REQ(N), .XLEN(XL)) bus();
    rocc_cmd_arbiter #(.N_REQ(N), .XLEN(XL), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          g;
        logic [6:0]  funct;
        logic [4:0]  rd;
        logic        xd;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } exp_cmd_t;

    typedef struct {
        int          idx;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_resp_t;

    exp_cmd_t  cq[$];
    exp_resp_t rq[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_cmd(input int i, input logic xd, input logic [4:0] rd, input logic [63:0] rs1);
        exp_cmd_t e;
        e.g = i; e.funct = {2'b10, rd}; e.rd = rd; e.xd = xd; e.rs1 = rs1; e.rs2 = ~rs1;
        cq.push_back(e);
    endtask

    task automatic drive(input int i, input logic xd, input logic [4:0] rd, input logic [63:0] rs1);
        bus.req_cmd_valid[i] = 1'b1;
        bus.req_cmd_xd[i]    = xd;
        bus.req_cmd_rd[i]    = rd;
        bus.req_cmd_funct[i] = {2'b10, rd};
        bus.req_cmd_rs1[i]   = rs1;
        bus.req_cmd_rs2[i]   = ~rs1;
    endtask

    // One command from requester i, expected to fire in this cycle.
    task automatic cmd(input int i, input logic xd, input logic [4:0] rd, input logic [63:0] rs1);
        expect_cmd(i, xd, rd, rs1);
        drive(i, xd, rd, rs1);
        bus.acc_cmd_ready = 1'b1;
        step();
        bus.req_cmd_valid[i] = 1'b0;
    endtask

    // One accelerator response, expected to be delivered to requester idx.
    task automatic resp(input int idx, input logic [63:0] data, input logic [4:0] rd);
        exp_resp_t e;
        e.idx = idx; e.rd = rd; e.data = data;
        rq.push_back(e);
        bus.acc_resp_valid = 1'b1;
        bus.acc_resp_data  = data;
        bus.acc_resp_rd    = rd;
        bus.req_resp_ready = '1;
        step();
        bus.acc_resp_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.acc_cmd_valid && bus.acc_cmd_ready) begin
                int gi;
                exp_cmd_t e;
                gi = -1;
                for (int i = 0; i < N; i++) if (bus.req_cmd_ready[i]) gi = i;
                n_cmp++;
                if (cq.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_unexpected: got grant %0d rs1 %0h, expected no command", gi, bus.acc_cmd_rs1);
                end else begin
                    e = cq.pop_front();
                    if (gi != e.g || bus.acc_cmd_funct !== e.funct || bus.acc_cmd_rd !== e.rd ||
                        bus.acc_cmd_xd !== e.xd || bus.acc_cmd_rs1 !== e.rs1 || bus.acc_cmd_rs2 !== e.rs2) begin
                        n_fail++;
                        $display("FAIL cmd_fields: got grant %0d rd %0d xd %0b rs1 %0h, expected grant %0d rd %0d xd %0b rs1 %0h",
                                 gi, bus.acc_cmd_rd, bus.acc_cmd_xd, bus.acc_cmd_rs1, e.g, e.rd, e.xd, e.rs1);
                    end
                end
            end
            if (bus.req_resp_valid != '0) begin
                n_cmp++;
                if (!$onehot(bus.req_resp_valid)) begin
                    n_fail++;
                    $display("FAIL resp_onehot: got %b expected one-hot", bus.req_resp_valid);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_resp_valid[i] && bus.req_resp_ready[i]) begin
                    exp_resp_t e;
                    n_cmp++;
                    if (rq.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: got req %0d data %0h, expected no response", i, bus.req_resp_data);
                    end else begin
                        e = rq.pop_front();
                        if (i != e.idx || bus.req_resp_data !== e.data || bus.req_resp_rd !== e.rd) begin
                            n_fail++;
                            $display("FAIL resp_route: got req %0d rd %0d data %0h, expected req %0d rd %0d data %0h",
                                     i, bus.req_resp_rd, bus.req_resp_data, e.idx, e.rd, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_cmd_valid = '0; bus.req_cmd_xd = '0; bus.req_cmd_rd = '0; bus.req_cmd_funct = '0;
        bus.req_cmd_rs1 = '0; bus.req_cmd_rs2 = '0; bus.req_resp_ready = '0;
        bus.acc_cmd_ready = 1'b0; bus.acc_resp_valid = 1'b0; bus.acc_resp_rd = '0;
        bus.acc_resp_data = '0; bus.acc_busy = 1'b0;

        // Reset state
        step(); step();
        chk("rst_acc_cmd_valid", 64'(bus.acc_cmd_valid), 0);
        chk("rst_cmd_ready", 64'(bus.req_cmd_ready), 0);
        chk("rst_resp_valid", 64'(bus.req_resp_valid), 0);
        chk("rst_acc_resp_ready", 64'(bus.acc_resp_ready), 1);
        chk("rst_busy", 64'(bus.req_busy), 0);
        chk("rst_orphan", 64'(bus.resp_orphan), 0);
        chk("rst_acc_cmd_rs1", bus.acc_cmd_rs1, 0);
        bus.acc_busy = 1'b1;
        #1 chk("rst_busy_acc", 64'(bus.req_busy), 64'h3);
        bus.acc_busy = 1'b0;
        reset = 1'b0;
        step();

        // Round robin with both requesters valid, xd=0
        expect_cmd(0, 1'b0, 5'd1, 64'hA0);
        expect_cmd(1, 1'b0, 5'd2, 64'hB0);
        expect_cmd(0, 1'b0, 5'd1, 64'hA0);
        expect_cmd(1, 1'b0, 5'd2, 64'hB0);
        drive(0, 1'b0, 5'd1, 64'hA0);
        drive(1, 1'b0, 5'd2, 64'hB0);
        bus.acc_cmd_ready = 1'b1;
        #1 chk("rr_busy_wait", 64'(bus.req_busy), 64'h2);
        repeat (4) step();
        bus.req_cmd_valid = '0;

        // Three xd=1 from req0, one from req1, in-order responses
        cmd(0, 1'b1, 5'd3, 64'h1);
        cmd(0, 1'b1, 5'd4, 64'h2);
        cmd(0, 1'b1, 5'd5, 64'h3);
        cmd(1, 1'b1, 5'd6, 64'h4);
        #1 chk("inorder_busy_set", 64'(bus.req_busy), 64'h3);
        bus.acc_resp_valid = 1'b1; bus.acc_resp_data = 64'h11; bus.req_resp_ready = 2'b10;
        #1;
        chk("bp_acc_resp_ready", 64'(bus.acc_resp_ready), 0);
        chk("bp_resp_valid", 64'(bus.req_resp_valid), 64'h1);
        resp(0, 64'h11, 5'd3);
        resp(0, 64'h22, 5'd4);
        resp(0, 64'h33, 5'd5);
        resp(1, 64'h44, 5'd6);
        #1 chk("inorder_busy_clear", 64'(bus.req_busy), 0);

        // Fill the ID FIFO, then req1 xd=1 must wait while req0 xd=0 goes through
        cmd(0, 1'b1, 5'd7, 64'h10);
        cmd(0, 1'b1, 5'd8, 64'h11);
        cmd(0, 1'b1, 5'd9, 64'h12);
        cmd(0, 1'b1, 5'd10, 64'h13);
        expect_cmd(0, 1'b0, 5'd11, 64'h20);
        drive(0, 1'b0, 5'd11, 64'h20);
        drive(1, 1'b1, 5'd12, 64'h30);
        bus.acc_cmd_ready = 1'b1;
        #1 chk("full_hold_ready", 64'(bus.req_cmd_ready), 64'h1);
        step();
        bus.req_cmd_valid[0] = 1'b0;
        #1;
        chk("full_blocked_valid", 64'(bus.acc_cmd_valid), 0);
        chk("full_blocked_ready", 64'(bus.req_cmd_ready), 0);
        expect_cmd(1, 1'b1, 5'd12, 64'h30);
        resp(0, 64'hA1, 5'd7);
        chk("full_req1_fires", 64'(bus.req_cmd_ready), 64'h2);
        step();
        bus.req_cmd_valid[1] = 1'b0;

        // Drop to DEPTH-1, then push and pop together across pointer wrap
        resp(0, 64'hA2, 5'd8);
        begin
            exp_resp_t e;
            e.idx = 0; e.rd = 5'd9; e.data = 64'hA3;
            rq.push_back(e);
        end
        expect_cmd(0, 1'b1, 5'd13, 64'h40);
        drive(0, 1'b1, 5'd13, 64'h40);
        bus.acc_cmd_ready = 1'b1;
        bus.acc_resp_valid = 1'b1; bus.acc_resp_data = 64'hA3; bus.acc_resp_rd = 5'd9;
        bus.req_resp_ready = '1;
        step();
        bus.req_cmd_valid[0] = 1'b0; bus.acc_resp_valid = 1'b0;
        cmd(1, 1'b1, 5'd14, 64'h50);
        drive(0, 1'b1, 5'd15, 64'h60);
        #1;
        chk("wrap_full_ready", 64'(bus.req_cmd_ready), 0);
        chk("wrap_full_valid", 64'(bus.acc_cmd_valid), 0);
        bus.req_cmd_valid[0] = 1'b0;
        resp(0, 64'hC1, 5'd10);
        resp(1, 64'hC2, 5'd12);
        resp(0, 64'hC3, 5'd13);
        resp(1, 64'hC4, 5'd14);
        #1 chk("wrap_busy_clear", 64'(bus.req_busy), 0);

        // Response with empty FIFO is consumed and flagged
        bus.acc_resp_valid = 1'b1; bus.acc_resp_data = 64'hDEAD; bus.req_resp_ready = '0;
        #1;
        chk("orph_acc_resp_ready", 64'(bus.acc_resp_ready), 1);
        chk("orph_resp_valid", 64'(bus.req_resp_valid), 0);
        chk("orph_flag_before", 64'(bus.resp_orphan), 0);
        step();
        bus.acc_resp_valid = 1'b0;
        #1 chk("orph_flag_set", 64'(bus.resp_orphan), 1);
        repeat (3) step();
        chk("orph_sticky", 64'(bus.resp_orphan), 1);

        // Reset mid-operation discards the outstanding ID
        cmd(0, 1'b1, 5'd16, 64'h70);
        #1 chk("pre_reset_busy", 64'(bus.req_busy), 64'h1);
        reset = 1'b1;
        step();
        chk("mid_reset_busy", 64'(bus.req_busy), 0);
        chk("mid_reset_orphan", 64'(bus.resp_orphan), 0);
        reset = 1'b0;
        bus.acc_resp_valid = 1'b1; bus.acc_resp_data = 64'hBEEF; bus.req_resp_ready = '1;
        #1 chk("post_reset_no_route", 64'(bus.req_resp_valid), 0);
        step();
        bus.acc_resp_valid = 1'b0;
        #1 chk("post_reset_orphan", 64'(bus.resp_orphan), 1);

        chk("cmd_queue_empty", 64'(cq.size()), 0);
        chk("resp_queue_empty", 64'(rq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
